// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: condition codes, flag bit positions, FSM states.
package branch_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_ZS = 4'd2;
  localparam logic [3:0] COND_ZC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_AL = 4'd6;
  localparam logic [3:0] COND_NV = 4'd7;

  // Bit positions inside the {equal, z, n} flag vector.
  localparam int unsigned FLAG_EQUAL = 2;
  localparam int unsigned FLAG_Z     = 1;
  localparam int unsigned FLAG_N     = 0;

  typedef enum logic [1:0] {
    StIdle,
    StWaitFlags,
    StResp
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator: decides taken/illegal from a 4-bit code and the flags.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       taken_o,
  output logic       illegal_o
);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = flags_i[FLAG_EQUAL];
      COND_NE: taken_o = ~flags_i[FLAG_EQUAL];
      COND_ZS: taken_o = flags_i[FLAG_Z];
      COND_ZC: taken_o = ~flags_i[FLAG_Z];
      COND_MI: taken_o = flags_i[FLAG_N];
      COND_PL: taken_o = ~flags_i[FLAG_N];
      COND_AL: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: holds the architectural flags, resolves branch requests (optionally
// waiting for the next flag update) and presents a held taken/target result to fetch.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned PC_INC  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_valid_i,
  input  logic              flag_equal_i,
  input  logic              flag_z_i,
  input  logic              flag_n_i,
  input  logic              br_valid_i,
  output logic              br_ready_o,
  input  logic [3:0]        br_cond_i,
  input  logic              br_wait_i,
  input  logic [ADDR_W-1:0] br_pc_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              res_taken_o,
  output logic [ADDR_W-1:0] res_target_o,
  output logic              res_flush_o,
  output logic              res_illegal_o,
  output logic              res_timeout_o,
  output logic [2:0]        flags_q_o
);

  state_e            state_q, state_d;
  logic [2:0]        flags_q, flags_in, eval_flags;
  logic [3:0]        cond_q, eval_cond;
  logic [ADDR_W-1:0] pc_q, off_q, eval_pc, eval_off;
  logic [7:0]        cnt_q, cnt_d;
  logic              capture, load_res, force_to;
  logic              cond_taken, cond_illegal, taken_eff;
  logic [ADDR_W-1:0] target;

  logic              res_taken_q, res_illegal_q, res_timeout_q;
  logic [ADDR_W-1:0] res_target_q;

  assign flags_in = {flag_equal_i, flag_z_i, flag_n_i};

  cond_eval u_cond_eval (
    .cond_i   (eval_cond),
    .flags_i  (eval_flags),
    .taken_o  (cond_taken),
    .illegal_o(cond_illegal)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    load_res   = 1'b0;
    force_to   = 1'b0;
    eval_cond  = cond_q;
    eval_pc    = pc_q;
    eval_off   = off_q;
    eval_flags = flags_in;
    case (state_q)
      StIdle: begin
        // Resolve straight from the request; forward same-cycle flags over the register.
        eval_cond  = br_cond_i;
        eval_pc    = br_pc_i;
        eval_off   = br_offset_i;
        eval_flags = flag_valid_i ? flags_in : flags_q;
        if (br_valid_i) begin
          capture = 1'b1;
          if (!br_wait_i || flag_valid_i) begin
            load_res = 1'b1;
            state_d  = StResp;
          end else begin
            cnt_d   = '0;
            state_d = StWaitFlags;
          end
        end
      end
      StWaitFlags: begin
        if (flag_valid_i) begin
          load_res = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(TIMEOUT)) begin
            load_res = 1'b1;
            force_to = 1'b1;
            state_d  = StResp;
          end
        end
      end
      StResp: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign taken_eff = cond_taken & ~force_to;
  assign target    = taken_eff ? (eval_pc + eval_off) : (eval_pc + ADDR_W'(PC_INC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      flags_q       <= 3'b000;
      cnt_q         <= '0;
      cond_q        <= '0;
      pc_q          <= '0;
      off_q         <= '0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
      res_timeout_q <= 1'b0;
      res_target_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (flag_valid_i) flags_q <= flags_in;
      if (capture) begin
        cond_q <= br_cond_i;
        pc_q   <= br_pc_i;
        off_q  <= br_offset_i;
      end
      if (load_res) begin
        res_taken_q   <= taken_eff;
        res_illegal_q <= cond_illegal;
        res_timeout_q <= force_to;
        res_target_q  <= target;
      end
    end
  end

  assign br_ready_o    = (state_q == StIdle);
  assign res_valid_o   = (state_q == StResp);
  assign res_taken_o   = res_taken_q;
  assign res_target_o  = res_target_q;
  assign res_flush_o   = res_valid_o & res_taken_q;
  assign res_illegal_o = res_illegal_q;
  assign res_timeout_o = res_timeout_q;
  assign flags_q_o     = flags_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic against a transaction model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flag_valid, flag_equal, flag_z, flag_n;
  logic        br_valid, br_ready, br_wait;
  logic [3:0]  br_cond;
  logic [31:0] br_pc, br_offset;
  logic        res_valid, res_ready, res_taken, res_flush, res_illegal, res_timeout;
  logic [31:0] res_target;
  logic [2:0]  flags_q;

  int n_checks = 0;
  int n_fail   = 0;

  branch_resolve_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flag_valid_i (flag_valid),
    .flag_equal_i (flag_equal),
    .flag_z_i     (flag_z),
    .flag_n_i     (flag_n),
    .br_valid_i   (br_valid),
    .br_ready_o   (br_ready),
    .br_cond_i    (br_cond),
    .br_wait_i    (br_wait),
    .br_pc_i      (br_pc),
    .br_offset_i  (br_offset),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_taken_o  (res_taken),
    .res_target_o (res_target),
    .res_flush_o  (res_flush),
    .res_illegal_o(res_illegal),
    .res_timeout_o(res_timeout),
    .flags_q_o    (flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [2:0]  m_flags;
  bit          m_waiting, m_resp;
  int          m_waited;
  logic [3:0]  m_cond;
  logic [31:0] m_pc, m_off, m_tgt;
  logic        m_taken, m_ill, m_to;

  function automatic logic cond_holds(input logic [3:0] c, input logic [2:0] f);
    case (c)
      4'd0:    return f[2];
      4'd1:    return !f[2];
      4'd2:    return f[1];
      4'd3:    return !f[1];
      4'd4:    return f[0];
      4'd5:    return !f[0];
      4'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic produce(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] off,
                         input logic [2:0] f, input logic to);
    m_taken   = !to && cond_holds(c, f);
    m_ill     = (c >= 4'd8);
    m_to      = to;
    m_tgt     = m_taken ? pc + off : pc + 32'd4;
    m_resp    = 1'b1;
    m_waiting = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_flags = 3'b000; m_waiting = 0; m_resp = 0; m_waited = 0;
      m_taken = 0; m_ill = 0; m_to = 0; m_tgt = 0;
    end else begin
      logic [2:0] nf;
      nf = {flag_equal, flag_z, flag_n};
      if (m_resp) begin
        if (res_ready) m_resp = 0;
      end else if (m_waiting) begin
        if (flag_valid) produce(m_cond, m_pc, m_off, nf, 1'b0);
        else begin
          m_waited++;
          if (m_waited == 255) produce(m_cond, m_pc, m_off, nf, 1'b1);
        end
      end else if (br_valid) begin
        m_cond = br_cond; m_pc = br_pc; m_off = br_offset;
        if (!br_wait || flag_valid) produce(br_cond, br_pc, br_offset,
                                            flag_valid ? nf : m_flags, 1'b0);
        else begin
          m_waiting = 1; m_waited = 0;
        end
      end
      if (flag_valid) m_flags = nf;
    end
  end

  // Every-cycle comparison against the model, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("br_ready", {31'd0, br_ready}, {31'd0, !(m_waiting || m_resp)});
      chk("res_valid", {31'd0, res_valid}, {31'd0, m_resp});
      chk("flags_q", {29'd0, flags_q}, {29'd0, m_flags});
      if (m_resp) begin
        chk("res_taken", {31'd0, res_taken}, {31'd0, m_taken});
        chk("res_target", res_target, m_tgt);
        chk("res_flush", {31'd0, res_flush}, {31'd0, m_taken});
        chk("res_illegal", {31'd0, res_illegal}, {31'd0, m_ill});
        chk("res_timeout", {31'd0, res_timeout}, {31'd0, m_to});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_flags(input logic v, input logic [2:0] f);
    flag_valid = v;
    {flag_equal, flag_z, flag_n} = f;
  endtask

  task automatic send(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] off,
                      input logic w);
    br_valid = 1'b1; br_cond = c; br_pc = pc; br_offset = off; br_wait = w;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; res_ready = 1'b0; br_valid = 1'b0; br_wait = 1'b0;
    br_cond = 4'd0; br_pc = '0; br_offset = '0;
    set_flags(1'b0, 3'b000);
    repeat (2) @(negedge clk);
    chk("reset br_ready", {31'd0, br_ready}, 32'd1);
    chk("reset res_valid", {31'd0, res_valid}, 32'd0);
    chk("reset flags", {29'd0, flags_q}, 32'd0);
    chk("reset target", res_target, 32'd0);
    rst_n = 1'b1;

    // EQ using registered flags
    @(negedge clk); set_flags(1'b1, 3'b100);
    @(negedge clk); set_flags(1'b0, 3'b000); send(4'd0, 32'h100, 32'h20, 1'b0);
    @(negedge clk); br_valid = 1'b0;
    chk("eq valid", {31'd0, res_valid}, 32'd1);
    chk("eq taken", {31'd0, res_taken}, 32'd1);
    chk("eq target", res_target, 32'h120);
    chk("eq flush", {31'd0, res_flush}, 32'd1);
    handshake();

    // NE waiting for a flag update three cycles later
    send(4'd1, 32'h200, 32'h40, 1'b1);
    @(negedge clk); br_valid = 1'b0;
    chk("wait ready0", {31'd0, br_ready}, 32'd0);
    @(negedge clk);
    chk("wait ready1", {31'd0, br_ready}, 32'd0);
    @(negedge clk);
    chk("wait ready2", {31'd0, br_ready}, 32'd0);
    chk("wait novalid", {31'd0, res_valid}, 32'd0);
    set_flags(1'b1, 3'b010);
    @(negedge clk); set_flags(1'b0, 3'b000);
    chk("wait valid", {31'd0, res_valid}, 32'd1);
    chk("wait taken", {31'd0, res_taken}, 32'd1);
    chk("wait target", res_target, 32'h240);
    handshake();

    // MI with forwarded flags and address wrap
    send(4'd4, 32'hFFFF_FFFC, 32'h8, 1'b0); set_flags(1'b1, 3'b001);
    @(negedge clk); br_valid = 1'b0; set_flags(1'b0, 3'b000);
    chk("mi taken", {31'd0, res_taken}, 32'd1);
    chk("mi target", res_target, 32'h4);
    chk("mi flags", {29'd0, flags_q}, 32'd1);
    handshake();

    // Reserved condition code, result held while downstream stalls
    send(4'd9, 32'h300, 32'h50, 1'b0);
    @(negedge clk); br_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("ill valid", {31'd0, res_valid}, 32'd1);
      chk("ill taken", {31'd0, res_taken}, 32'd0);
      chk("ill flag", {31'd0, res_illegal}, 32'd1);
      chk("ill target", res_target, 32'h304);
      @(negedge clk);
    end
    handshake();

    // Timeout after 255 waiting cycles
    send(4'd6, 32'h400, 32'h10, 1'b1);
    @(negedge clk); br_valid = 1'b0;
    lat = 400;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (res_valid) begin
        lat = i;
        break;
      end
    end
    chk("to latency", lat, 32'd255);
    chk("to timeout", {31'd0, res_timeout}, 32'd1);
    chk("to taken", {31'd0, res_taken}, 32'd0);
    chk("to target", res_target, 32'h404);
    handshake();

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      set_flags(($urandom_range(0, 9) < 3), 3'($urandom));
      br_valid  = ($urandom_range(0, 1) == 1);
      br_cond   = 4'($urandom);
      br_wait   = ($urandom_range(0, 9) < 3);
      br_pc     = $urandom;
      br_offset = $urandom;
      res_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end
    br_valid = 1'b0; res_ready = 1'b1; set_flags(1'b0, 3'b000);
    repeat (3) @(negedge clk);
    res_ready = 1'b0;

    // Asynchronous reset while a result is held
    send(4'd6, 32'h500, 32'h4, 1'b0); set_flags(1'b1, 3'b111);
    @(negedge clk); br_valid = 1'b0; set_flags(1'b0, 3'b000);
    chk("pre-rst valid", {31'd0, res_valid}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst valid", {31'd0, res_valid}, 32'd0);
    chk("rst flags", {29'd0, flags_q}, 32'd0);
    chk("rst ready", {31'd0, br_ready}, 32'd1);
    chk("rst target", res_target, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst ready", {31'd0, br_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
